proc_controller: RTL and testbench

//  Sequencing FSM for the 10-bit processor datapath: instruction register, 4-entry register file, multi-step ALU.

---
 rtl/proc_controller.sv | 178 +++++++++++++++++
 tb/tb_proc_controller.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/proc_controller.sv
// proc_controller: step sequencer for the 10-bit processor datapath.
//   T0 fetches the instruction (IRin). T1..T3 drive the register file, the ALU
//   and the bus-source controls. DONE is high on the last step of an instruction.
// Ports:
//   CLK   step clock; all state changes happen on its rising edge
//   CLR   synchronous active-high reset; forces every output except STEP to 0
//   INSTR instruction register output: {opcode, Rx, Ry, unused}
//   IRin  instruction register load enable
//   EXT   Data_in drives the bus
//   ENW   register-file write enable
//   WRA   register-file write address
//   ENR0  register-file read port 0 drives the bus
//   RDA0  read port 0 address
//   RDA1  read port 1 address (Rx, for display)
//   FN    ALU function select
//   Ain   ALU A-operand latch enable
//   Gin   ALU result latch enable
//   Gout  ALU result drives the bus
//   STEP  current timestep T0..T3
//   DONE  final step of the current instruction
module proc_controller #(
  parameter int unsigned DW  = 10,
  parameter int unsigned RAW = 2,
  parameter int unsigned FNW = 4
) (
  input  logic           CLK,
  input  logic           CLR,
  input  logic [DW-1:0]  INSTR,
  output logic           IRin,
  output logic           EXT,
  output logic           ENW,
  output logic [RAW-1:0] WRA,
  output logic           ENR0,
  output logic [RAW-1:0] RDA0,
  output logic [RAW-1:0] RDA1,
  output logic [FNW-1:0] FN,
  output logic           Ain,
  output logic           Gin,
  output logic           Gout,
  output logic [1:0]     STEP,
  output logic           DONE
);

  localparam int unsigned OP_LSB = DW - FNW;
  localparam int unsigned RX_LSB = OP_LSB - RAW;
  localparam int unsigned RY_LSB = RX_LSB - RAW;

  localparam logic [FNW-1:0] OP_LOAD = FNW'(0);
  localparam logic [FNW-1:0] OP_MOV  = FNW'(1);
  localparam logic [FNW-1:0] OP_ADD  = FNW'(2);
  localparam logic [FNW-1:0] OP_XOR  = FNW'(6);
  localparam logic [FNW-1:0] OP_NOT  = FNW'(7);
  localparam logic [FNW-1:0] OP_NEG  = FNW'(8);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_e;

  step_e step_q, step_d;

  logic [FNW-1:0] opcode;
  logic [RAW-1:0] rx, ry;
  logic           is_binary, is_unary;
  logic           unused_instr_lsbs;

  // Instruction field decode
  assign opcode    = INSTR[DW-1:OP_LSB];
  assign rx        = INSTR[OP_LSB-1:RX_LSB];
  assign ry        = INSTR[RX_LSB-1:RY_LSB];
  assign is_binary = (opcode >= OP_ADD) && (opcode <= OP_XOR);
  assign is_unary  = (opcode == OP_NOT) || (opcode == OP_NEG);
  assign unused_instr_lsbs = ^INSTR[RY_LSB-1:0];

  // Step register
  always_ff @(posedge CLK) begin
    if (CLR) begin
      step_q <= T0;
    end else begin
      step_q <= step_d;
    end
  end

  assign STEP = step_q;

  // Next step and per-step control decode
  always_comb begin
    step_d = T0;
    IRin   = 1'b0;
    EXT    = 1'b0;
    ENW    = 1'b0;
    WRA    = '0;
    ENR0   = 1'b0;
    RDA0   = '0;
    RDA1   = '0;
    FN     = '0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    DONE   = 1'b0;

    unique case (step_q)
      T0: begin
        IRin   = 1'b1;
        step_d = T1;
      end
      T1: begin
        RDA1 = rx;
        if (opcode == OP_LOAD) begin
          EXT  = 1'b1;
          ENW  = 1'b1;
          WRA  = rx;
          DONE = 1'b1;
        end else if (opcode == OP_MOV) begin
          ENR0 = 1'b1;
          RDA0 = ry;
          ENW  = 1'b1;
          WRA  = rx;
          DONE = 1'b1;
        end else if (is_binary) begin
          ENR0   = 1'b1;
          RDA0   = rx;
          Ain    = 1'b1;
          step_d = T2;
        end else if (is_unary) begin
          ENR0   = 1'b1;
          RDA0   = ry;
          FN     = opcode;
          Gin    = 1'b1;
          step_d = T2;
        end else begin
          DONE = 1'b1;
        end
      end
      T2: begin
        RDA1 = rx;
        if (is_binary) begin
          ENR0   = 1'b1;
          RDA0   = ry;
          FN     = opcode;
          Gin    = 1'b1;
          step_d = T3;
        end else if (is_unary) begin
          Gout = 1'b1;
          ENW  = 1'b1;
          WRA  = rx;
          DONE = 1'b1;
        end
      end
      T3: begin
        // Only binary ops legitimately reach T3; anything else just returns to fetch
        RDA1 = rx;
        if (is_binary) begin
          Gout = 1'b1;
          ENW  = 1'b1;
          WRA  = rx;
          DONE = 1'b1;
        end
      end
      default: step_d = T0;
    endcase

    // Reset masks every control so an aborted instruction writes nothing
    if (CLR) begin
      step_d = T0;
      IRin   = 1'b0;
      EXT    = 1'b0;
      ENW    = 1'b0;
      WRA    = '0;
      ENR0   = 1'b0;
      RDA0   = '0;
      RDA1   = '0;
      FN     = '0;
      Ain    = 1'b0;
      Gin    = 1'b0;
      Gout   = 1'b0;
      DONE   = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_controller.sv
// tb_proc_controller: directed plus randomized instruction streams for
// proc_controller, checked each step against a per-instruction step model.
module tb_proc_controller;

  logic       CLK;
  logic       CLR;
  logic [9:0] INSTR;
  logic       IRin, EXT, ENW, ENR0, Ain, Gin, Gout, DONE;
  logic [1:0] WRA, RDA0, RDA1, STEP;
  logic [3:0] FN;

  int n_vec = 0;
  int n_err = 0;
  int m_step = 0;

  proc_controller #(.DW(10), .RAW(2), .FNW(4)) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .INSTR(INSTR),
    .IRin (IRin),
    .EXT  (EXT),
    .ENW  (ENW),
    .WRA  (WRA),
    .ENR0 (ENR0),
    .RDA0 (RDA0),
    .RDA1 (RDA1),
    .FN   (FN),
    .Ain  (Ain),
    .Gin  (Gin),
    .Gout (Gout),
    .STEP (STEP),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (step %0d instr %b clr %b)",
               tag, obs, exp, m_step, INSTR, CLR);
    end
  endtask

  // Number of steps (including fetch) an opcode occupies
  function automatic int instr_len(input logic [3:0] op);
    if (op >= 4'd2 && op <= 4'd6) return 4;
    if (op == 4'd7 || op == 4'd8) return 3;
    return 2;
  endfunction

  // Expected outputs for one step, packed as
  // {IRin,EXT,ENW,WRA,ENR0,RDA0,RDA1,FN,Ain,Gin,Gout,STEP,DONE}
  function automatic logic [19:0] expect_vec(input logic clr, input int step,
                                             input logic [9:0] ins);
    logic       irin, ext, enw, enr0, ain, gin, gout, done;
    logic [1:0] wra, rda0, rda1, rx, ry;
    logic [3:0] op, fn;
    int         len;
    irin = 0; ext = 0; enw = 0; enr0 = 0; ain = 0; gin = 0; gout = 0; done = 0;
    wra = 0; rda0 = 0; rda1 = 0; fn = 0;
    op = ins[9:6]; rx = ins[5:4]; ry = ins[3:2];
    len = instr_len(op);
    if (!clr) begin
      if (step == 0) begin
        irin = 1;
      end else begin
        rda1 = rx;
        // The last step of every instruction writes Rx (except NOP) and raises DONE
        if (step == len - 1) begin
          done = 1;
          if (op == 4'd0) begin
            ext = 1; enw = 1; wra = rx;
          end else if (op == 4'd1) begin
            enr0 = 1; rda0 = ry; enw = 1; wra = rx;
          end else if (len > 2) begin
            gout = 1; enw = 1; wra = rx;
          end
        end else if (len == 4 && step == 1) begin
          enr0 = 1; rda0 = rx; ain = 1;
        end else begin
          // Operation step that feeds Ry into the ALU and latches the result
          enr0 = 1; rda0 = ry; fn = op; gin = 1;
        end
      end
    end
    return {irin, ext, enw, wra, enr0, rda0, rda1, fn, ain, gin, gout, 2'(step), done};
  endfunction

  // Apply one step, check it, advance across the edge and the model with it
  task automatic cyc(input logic clr, input logic [9:0] ins);
    logic [19:0] exp_v, obs_v;
    CLR   = clr;
    INSTR = ins;
    #3;
    obs_v = {IRin, EXT, ENW, WRA, ENR0, RDA0, RDA1, FN, Ain, Gin, Gout, STEP, DONE};
    exp_v = expect_vec(clr, m_step, ins);
    chk("outs", 32'(obs_v), 32'(exp_v));
    chk("one_bus_driver", 32'((2'(EXT) + 2'(ENR0) + 2'(Gout)) <= 2'd1), 32'd1);
    chk("irin_only_t0", 32'(IRin && (STEP != 2'd0)), 32'd0);
    @(posedge CLK);
    #1;
    if (clr) m_step = 0;
    else     m_step = (m_step + 1 >= instr_len(ins[9:6])) ? 0 : m_step + 1;
  endtask

  // Run one instruction from fetch; abort_at < 0 means no abort
  task automatic run_instr(input logic [9:0] ins, input int abort_at);
    logic aborted;
    aborted = 1'b0;
    for (int s = 0; s < 6; s++) begin
      cyc(s == abort_at, ins);
      if (s == abort_at) aborted = 1'b1;
      if (m_step == 0) break;
    end
    if (m_step != 0) chk("instr_terminates", 32'(m_step), 32'd0);
    if (aborted) cyc(1'b1, ins);
  endtask

  initial begin
    CLR   = 1'b1;
    INSTR = 10'd0;
    @(posedge CLK);
    #1;
    m_step = 0;
    cyc(1'b1, 10'd0);
    chk("step_after_reset", 32'(STEP), 32'd0);

    run_instr(10'b0000_10_00_00, -1);  // LOAD R2
    run_instr(10'b0010_01_11_00, -1);  // ADD R1,R3
    run_instr(10'b0111_00_10_00, -1);  // NOT R0,R2
    run_instr(10'b1111_01_10_11, -1);  // NOP
    run_instr(10'b0001_11_01_00, -1);  // MOV R3,R1
    run_instr(10'b1000_10_01_00, -1);  // NEG R2,R1
    run_instr(10'b0010_01_11_00, 2);   // ADD aborted in T2
    chk("step_after_abort", 32'(STEP), 32'd0);

    for (int i = 0; i < 300; i++) begin
      logic [9:0] ins;
      int         ab;
      ins = 10'($urandom);
      ab  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_instr(ins, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
